// File: rtl/timer_down_counter_pkg.sv
// ============================================================================
// Module      : timer_down_counter_pkg
// Description : Shared definitions for the down-counting timer: FSM state
//               encodings and the CeilLog2 width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    // Number of bits needed to hold values 0..value-1.
    // CeilLog2(1) = 0, CeilLog2(4) = 2, CeilLog2(5) = 3.
    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : timer_down_counter_pkg

`default_nettype wire

// File: rtl/timer_down_counter_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Modulo-MODULUS cycle counter producing a one-cycle tick on
//               the last count while enabled.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-low reset
//               clear  - synchronous return to 0 (wins over enable)
//               enable - advance the counter this cycle
//               tick   - high when enabled and counter == MODULUS-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_down_counter_pkg::*;
#(
    parameter int MODULUS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // At least one bit so MODULUS=1 still yields a legal vector.
    localparam int W = (CeilLog2(MODULUS) < 1) ? 1 : CeilLog2(MODULUS);
    localparam logic [W-1:0] C_LAST = W'(MODULUS - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_last;

    assign w_at_last = (r_cnt == C_LAST);
    assign tick      = enable && w_at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/timer_down_counter.sv
// ============================================================================
// Module      : timer_down_counter
// Description : Prescaled down-counting timer with one-shot / auto-reload
//               modes, abort, and a registered one-cycle done pulse.
// Ports       : clk         - clock, rising edge
//               reset       - asynchronous active-low reset
//               start       - load load_value and begin counting
//               load_value  - initial count (sampled with start)
//               auto_reload - periodic mode select (sampled with start)
//               abort       - cancel, return to idle, no done pulse
//               busy        - high while running
//               done        - one-cycle pulse on expiry
//               count       - remaining count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_down_counter
    import timer_down_counter_pkg::*;
#(
    parameter int NBITS    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] load_value,
    input  logic             auto_reload,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] count
);

    timer_state_t     r_state;
    timer_state_t     w_next_state;
    logic [NBITS-1:0] r_count;
    logic [NBITS-1:0] w_next_count;
    logic [NBITS-1:0] r_reload;
    logic [NBITS-1:0] w_next_reload;
    logic             r_mode;
    logic             w_next_mode;
    logic             r_done;
    logic             r_busy;

    logic w_tick;
    logic w_presc_clear;
    logic w_presc_enable;

    // The prescaler only runs in RUN; any restart or abort, and every cycle
    // outside RUN, returns it to 0 so a fresh run always starts at phase 0.
    assign w_presc_enable = (r_state == ST_RUN);
    assign w_presc_clear  = (r_state != ST_RUN) || start || abort;

    tick_prescaler #(
        .MODULUS (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_presc_clear),
        .enable (w_presc_enable),
        .tick   (w_tick)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_reload = r_reload;
        w_next_mode   = r_mode;

        if (abort) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
        end else if (start) begin
            if (load_value != '0) begin
                w_next_state  = ST_RUN;
                w_next_count  = load_value;
                w_next_reload = load_value;
                w_next_mode   = auto_reload;
            end else begin
                // Zero load expires immediately and can never be periodic.
                w_next_state = ST_DONE;
                w_next_count = '0;
                w_next_mode  = 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_count = '0;
                end
                ST_RUN: begin
                    if (w_tick) begin
                        // <= 1 rather than == 1 so a zero count can never wrap.
                        if (r_count <= NBITS'(1)) begin
                            w_next_count = '0;
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_count = r_count - NBITS'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (r_mode) begin
                        w_next_state = ST_RUN;
                        w_next_count = r_reload;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_count = '0;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_count = '0;
                end
            endcase
        end
    end

    // done/busy are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_reload <= w_next_reload;
            r_mode   <= w_next_mode;
            r_done   <= (w_next_state == ST_DONE);
            r_busy   <= (w_next_state == ST_RUN);
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;

endmodule : timer_down_counter

`default_nettype wire

// File: tb/tb_timer_down_counter.sv
// ============================================================================
// Module      : tb_timer_down_counter
// Description : Directed self-checking bench for timer_down_counter with one
//               PRESCALE=4 instance and one PRESCALE=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_down_counter;

    logic       clk;
    logic       reset;

    logic       start4, auto4, abort4;
    logic [7:0] load4;
    logic       busy4, done4;
    logic [7:0] count4;

    logic       start1, auto1, abort1;
    logic [7:0] load1;
    logic       busy1, done1;
    logic [7:0] count1;

    int passed;
    int failed;
    int total;

    timer_down_counter #(.NBITS(8), .PRESCALE(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (start4),
        .load_value  (load4),
        .auto_reload (auto4),
        .abort       (abort4),
        .busy        (busy4),
        .done        (done4),
        .count       (count4)
    );

    timer_down_counter #(.NBITS(8), .PRESCALE(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start1),
        .load_value  (load1),
        .auto_reload (auto1),
        .abort       (abort1),
        .busy        (busy1),
        .done        (done1),
        .count       (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        reset  = 1'b0;
        start4 = 0; auto4 = 0; abort4 = 0; load4 = 0;
        start1 = 0; auto1 = 0; abort1 = 0; load1 = 0;

        // Reset state
        #1;
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_count4", count4, 0);
        chk("rst_count1", count1, 0);
        step(); step();
        reset = 1'b1;
        step();

        // One-shot, PRESCALE=4, N=3: done at edge 12
        start4 = 1; load4 = 8'd3; auto4 = 0;
        step();
        start4 = 0;
        chk("os_e0_busy", busy4, 1);
        chk("os_e0_count", count4, 3);
        for (int e = 1; e <= 13; e++) begin
            step();
            chk($sformatf("os_e%0d_done", e), done4, (e == 12) ? 1 : 0);
            chk($sformatf("os_e%0d_busy", e), busy4, (e < 12) ? 1 : 0);
            chk($sformatf("os_e%0d_count", e), count4, (e < 12) ? 3 - e / 4 : 0);
        end

        // Periodic, PRESCALE=1, N=2: done at edges 2,5,8
        start1 = 1; load1 = 8'd2; auto1 = 1;
        step();
        start1 = 0; auto1 = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("per_e%0d_done", e), done1, (e == 2 || e == 5 || e == 8) ? 1 : 0);
        end
        chk("per_e9_count", count1, 2);
        abort1 = 1;
        step();
        abort1 = 0;
        chk("per_abort_busy", busy1, 0);
        chk("per_abort_count", count1, 0);
        chk("per_abort_done", done1, 0);
        for (int e = 0; e < 4; e++) begin
            step();
            chk("per_after_abort_done", done1, 0);
        end

        // Zero load (auto_reload must be ignored)
        start1 = 1; load1 = 8'd0; auto1 = 1;
        step();
        start1 = 0; auto1 = 0;
        chk("zero_e0_done", done1, 1);
        chk("zero_e0_busy", busy1, 0);
        chk("zero_e0_count", count1, 0);
        step();
        chk("zero_e1_done", done1, 0);
        chk("zero_e1_busy", busy1, 0);
        step();
        chk("zero_e2_done", done1, 0);
        chk("zero_e2_busy", busy1, 0);

        // Restart, PRESCALE=4: load 5, restart with 7 when count==2
        start4 = 1; load4 = 8'd5;
        step();
        start4 = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("rs_first_done", done4, 0);
        end
        chk("rs_count_at_e12", count4, 2);
        start4 = 1; load4 = 8'd7;
        step();
        start4 = 0;
        chk("rs_reload_count", count4, 7);
        chk("rs_reload_busy", busy4, 1);
        for (int i = 1; i <= 29; i++) begin
            step();
            chk($sformatf("rs_i%0d_done", i), done4, (i == 28) ? 1 : 0);
        end

        // Abort and start together in RUN -> IDLE
        start4 = 1; load4 = 8'd6;
        step();
        start4 = 0;
        step(); step(); step();
        chk("pri_running", busy4, 1);
        abort4 = 1; start4 = 1; load4 = 8'd9;
        step();
        abort4 = 0; start4 = 0;
        chk("pri_busy", busy4, 0);
        chk("pri_count", count4, 0);
        chk("pri_done", done4, 0);
        step();
        chk("pri_idle_busy", busy4, 0);

        // Asynchronous reset mid-RUN at count 4
        start4 = 1; load4 = 8'd5;
        step();
        start4 = 0;
        for (int e = 1; e <= 5; e++) step();
        chk("ar_count_before", count4, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_busy", busy4, 0);
        chk("ar_count", count4, 0);
        chk("ar_done", done4, 0);
        step();
        // Release reset with a start already presented: honoured on first edge
        reset = 1'b1;
        start1 = 1; load1 = 8'd1; auto1 = 0;
        step();
        start1 = 0;
        chk("post_rst_busy", busy1, 1);
        chk("post_rst_count", count1, 1);
        step();
        chk("post_rst_done", done1, 1);
        for (int e = 0; e < 24; e++) begin
            step();
            chk("ar_no_done4", done4, 0);
        end

        // Boundary: load 255 at PRESCALE=1
        start1 = 1; load1 = 8'd255; auto1 = 0;
        step();
        start1 = 0;
        chk("bnd_e0_count", count1, 255);
        for (int e = 1; e <= 256; e++) begin
            step();
            chk($sformatf("bnd_e%0d_done", e), done1, (e == 255) ? 1 : 0);
            chk($sformatf("bnd_e%0d_count", e), count1, (e < 255) ? 255 - e : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_timer_down_counter

`default_nettype wire
